wb_port_arbiter: RTL and testbench

- Shares the register file's single write port between two producers: the execute stage (ALU results) and the load unit (load data).
- Each producer pushes into its own small FIFO through a valid/ready handshake.
- A round-robin scheduler pops one entry per cycle and drives the registered wb/wb_r/wb_data signals that feed the decode stage's register file.
- Raises a stall to the front end whenever either FIFO is full.

---
 rtl/wb_port_arbiter_if.sv | 37 +++
 rtl/wb_port_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Bundle of producer handshakes and the register-file write port for
// wb_port_arbiter. clk/rst stay outside the interface.
//
// Handshake: a producer raises *_valid_i with its register index and data and
// keeps all three stable until it sees *_ready_o = 1 at a rising edge; the
// entry is taken at exactly that edge. *_ready_o depends only on the FIFO
// count, never on *_valid_i or on the same-cycle pop.
interface wb_port_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  logic          alu_valid_i;
  logic [AW-1:0] alu_r_i;
  logic [DW-1:0] alu_data_i;
  logic          alu_ready_o;
  logic          ld_valid_i;
  logic [AW-1:0] ld_r_i;
  logic [DW-1:0] ld_data_i;
  logic          ld_ready_o;
  logic          wb_o;
  logic [AW-1:0] wb_r_o;
  logic [DW-1:0] wb_data_o;
  logic          stall_o;
  logic          grant_o;

  // Arbiter side.
  modport slave (
    input  alu_valid_i, alu_r_i, alu_data_i, ld_valid_i, ld_r_i, ld_data_i,
    output alu_ready_o, ld_ready_o, wb_o, wb_r_o, wb_data_o, stall_o, grant_o
  );

  // Producer / register-file side.
  modport master (
    output alu_valid_i, alu_r_i, alu_data_i, ld_valid_i, ld_r_i, ld_data_i,
    input  alu_ready_o, ld_ready_o, wb_o, wb_r_o, wb_data_o, stall_o, grant_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register file's single write port between the ALU and the load
// unit. Each source owns a small circular FIFO; a round-robin scheduler pops
// at most one entry per cycle into the registered wb/wb_r/wb_data outputs.
module wb_port_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + DW;

  logic [EW-1:0] alu_mem [DEPTH];
  logic [EW-1:0] ld_mem  [DEPTH];
  logic [PW-1:0] alu_wp, alu_rp, ld_wp, ld_rp;
  logic [CW-1:0] alu_cnt, ld_cnt;
  logic          alu_full, ld_full, alu_ne, ld_ne;
  logic          alu_push, ld_push, alu_pop, ld_pop;
  logic          last_grant;

  logic          wb_q, grant_q;
  logic [AW-1:0] wb_r_q;
  logic [DW-1:0] wb_data_q;

  assign alu_full = (alu_cnt == CW'(DEPTH));
  assign ld_full  = (ld_cnt == CW'(DEPTH));
  assign alu_ne   = (alu_cnt != '0);
  assign ld_ne    = (ld_cnt != '0);

  assign alu_push = bus.alu_valid_i & ~alu_full;
  assign ld_push  = bus.ld_valid_i & ~ld_full;

  assign bus.alu_ready_o = ~alu_full;
  assign bus.ld_ready_o  = ~ld_full;
  assign bus.stall_o     = alu_full | ld_full;
  assign bus.wb_o        = wb_q;
  assign bus.wb_r_o      = wb_r_q;
  assign bus.wb_data_o   = wb_data_q;
  assign bus.grant_o     = grant_q;

  // Round-robin pick on pre-edge counts: a lone non-empty FIFO always wins,
  // otherwise the source not served last time goes.
  always_comb begin
    alu_pop = 1'b0;
    ld_pop  = 1'b0;
    if (alu_ne && ld_ne) begin
      alu_pop = last_grant;
      ld_pop  = ~last_grant;
    end else begin
      alu_pop = alu_ne;
      ld_pop  = ld_ne;
    end
  end

  // ALU FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_wp  <= '0;
      alu_rp  <= '0;
      alu_cnt <= '0;
    end else begin
      if (alu_push) alu_wp <= alu_wp + PW'(1);
      if (alu_pop)  alu_rp <= alu_rp + PW'(1);
      case ({alu_push, alu_pop})
        2'b10:   alu_cnt <= alu_cnt + CW'(1);
        2'b01:   alu_cnt <= alu_cnt - CW'(1);
        default: alu_cnt <= alu_cnt;
      endcase
    end
  end

  // Load FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_wp  <= '0;
      ld_rp  <= '0;
      ld_cnt <= '0;
    end else begin
      if (ld_push) ld_wp <= ld_wp + PW'(1);
      if (ld_pop)  ld_rp <= ld_rp + PW'(1);
      case ({ld_push, ld_pop})
        2'b10:   ld_cnt <= ld_cnt + CW'(1);
        2'b01:   ld_cnt <= ld_cnt - CW'(1);
        default: ld_cnt <= ld_cnt;
      endcase
    end
  end

  // FIFO storage; stale contents are harmless because counts gate every read.
  always_ff @(posedge clk) begin
    if (alu_push) alu_mem[alu_wp] <= {bus.alu_r_i, bus.alu_data_i};
    if (ld_push)  ld_mem[ld_wp]   <= {bus.ld_r_i, bus.ld_data_i};
  end

  // Registered write port; index/data/grant hold through idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q       <= 1'b0;
      wb_r_q     <= '0;
      wb_data_q  <= '0;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      wb_q <= alu_pop | ld_pop;
      if (alu_pop) begin
        {wb_r_q, wb_data_q} <= alu_mem[alu_rp];
        grant_q             <= 1'b0;
        last_grant          <= 1'b0;
      end else if (ld_pop) begin
        {wb_r_q, wb_data_q} <= ld_mem[ld_rp];
        grant_q             <= 1'b1;
        last_grant          <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int W     = AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  wb_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Scoreboard: entries accepted per source, in push order, awaiting write.
  logic [W-1:0] alu_q[$];
  logic [W-1:0] ld_q[$];
  bit            m_last;
  bit            m_g;
  logic [AW-1:0] m_r;
  logic [DW-1:0] m_d;
  int            n_acc, n_wr, n_55;

  // Producer state: request held until accepted.
  bit            a_busy, l_busy;
  logic [AW-1:0] a_r, l_r;
  logic [DW-1:0] a_d, l_d;

  typedef struct {
    logic          av;
    logic [AW-1:0] ar;
    logic [DW-1:0] ad;
    logic          lv;
    logic [AW-1:0] lr;
    logic [DW-1:0] ld;
    logic          ewb;
    logic [AW-1:0] er;
    logic [DW-1:0] ed;
    logic          eg;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.alu_valid_i = 1'b0; bus.alu_r_i = '0; bus.alu_data_i = '0;
    bus.ld_valid_i  = 1'b0; bus.ld_r_i  = '0; bus.ld_data_i  = '0;
    a_busy = 1'b0; l_busy = 1'b0;
  endtask

  task automatic model_reset();
    alu_q.delete(); ld_q.delete();
    m_last = 1'b1; m_g = 1'b0; m_r = '0; m_d = '0;
    n_acc = 0; n_wr = 0;
  endtask

  // Asserts rst between edges and checks outputs clear without a clock edge.
  task automatic do_reset();
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    chk("rst_wb", 64'(bus.wb_o), 64'(0));
    chk("rst_stall", 64'(bus.stall_o), 64'(0));
    chk("rst_wb_r", 64'(bus.wb_r_o), 64'(0));
    chk("rst_wb_data", 64'(bus.wb_data_o), 64'(0));
    chk("rst_grant", 64'(bus.grant_o), 64'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_alu_ready", 64'(bus.alu_ready_o), 64'(1));
    chk("rst_ld_ready", 64'(bus.ld_ready_o), 64'(1));
    model_reset();
  endtask

  // One clock with scoreboard checking of readiness, arbitration and output.
  task automatic cycle(output bit a_acc, output bit l_acc);
    int sa, sl;
    bit pa, pl;
    logic [W-1:0] a_e, l_e, head;
    #1;
    sa = alu_q.size();
    sl = ld_q.size();
    chk("alu_ready", 64'(bus.alu_ready_o), 64'(sa != DEPTH));
    chk("ld_ready", 64'(bus.ld_ready_o), 64'(sl != DEPTH));
    chk("stall", 64'(bus.stall_o), 64'((sa == DEPTH) || (sl == DEPTH)));
    a_acc = bus.alu_valid_i && (sa != DEPTH);
    l_acc = bus.ld_valid_i && (sl != DEPTH);
    a_e = {bus.alu_r_i, bus.alu_data_i};
    l_e = {bus.ld_r_i, bus.ld_data_i};
    pa = (sa != 0) && ((sl == 0) || m_last);
    pl = (sl != 0) && ((sa == 0) || !m_last);
    @(posedge clk);
    #1;
    if (pa) begin
      head = alu_q.pop_front();
      m_last = 1'b0; m_g = 1'b0; {m_r, m_d} = head;
    end else if (pl) begin
      head = ld_q.pop_front();
      m_last = 1'b1; m_g = 1'b1; {m_r, m_d} = head;
    end
    chk("wb", 64'(bus.wb_o), 64'(pa || pl));
    chk("wb_r", 64'(bus.wb_r_o), 64'(m_r));
    chk("wb_data", 64'(bus.wb_data_o), 64'(m_d));
    chk("grant", 64'(bus.grant_o), 64'(m_g));
    if (bus.wb_o) begin
      n_wr++;
      if (bus.wb_r_o == AW'(5) && bus.wb_data_o == DW'(32'h55)) n_55++;
    end
    if (a_acc) begin alu_q.push_back(a_e); n_acc++; end
    if (l_acc) begin ld_q.push_back(l_e); n_acc++; end
  endtask

  task automatic step();
    bit aa, la;
    bus.alu_valid_i = a_busy; bus.alu_r_i = a_r; bus.alu_data_i = a_d;
    bus.ld_valid_i  = l_busy; bus.ld_r_i  = l_r; bus.ld_data_i  = l_d;
    cycle(aa, la);
    if (aa) a_busy = 1'b0;
    if (la) l_busy = 1'b0;
  endtask

  task automatic drain();
    repeat (2 * DEPTH + 4) step();
    chk("writes_eq_accepts", 64'(n_wr), 64'(n_acc));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int ai, li, rejects;
    bit saw_full, bp_acc;

    idle_inputs();
    model_reset();
    do_reset();

    // Directed rows: contention, single ALU write, register 0 via load.
    vecs[0] = '{1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, 1'b0, 4'd0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd1, 32'h11, 1'b0};
    vecs[2] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 32'h22, 1'b1};
    vecs[3] = '{1'b1, 4'd3, 32'hAA, 1'b0, 4'd0, 32'h0, 1'b0, 4'd2, 32'h22, 1'b1};
    vecs[4] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 32'hAA, 1'b0};
    vecs[5] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd3, 32'hAA, 1'b0};
    vecs[6] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 32'hDEADBEEF, 1'b0, 4'd3, 32'hAA, 1'b0};
    vecs[7] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 32'hDEADBEEF, 1'b1};
    vecs[8] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'hDEADBEEF, 1'b1};
    for (int i = 0; i < 9; i++) begin
      bus.alu_valid_i = vecs[i].av; bus.alu_r_i = vecs[i].ar; bus.alu_data_i = vecs[i].ad;
      bus.ld_valid_i  = vecs[i].lv; bus.ld_r_i  = vecs[i].lr; bus.ld_data_i  = vecs[i].ld;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_wb", i), 64'(bus.wb_o), 64'(vecs[i].ewb));
      chk($sformatf("vec%0d_wb_r", i), 64'(bus.wb_r_o), 64'(vecs[i].er));
      chk($sformatf("vec%0d_wb_data", i), 64'(bus.wb_data_o), 64'(vecs[i].ed));
      chk($sformatf("vec%0d_grant", i), 64'(bus.grant_o), 64'(vecs[i].eg));
      chk($sformatf("vec%0d_stall", i), 64'(bus.stall_o), 64'(0));
      chk($sformatf("vec%0d_readies", i), 64'({bus.alu_ready_o, bus.ld_ready_o}), 64'(2'b11));
    end

    // Alternation and full: both producers push every cycle.
    do_reset();
    ai = 0; li = 0; saw_full = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!a_busy) begin a_r = AW'(4 + ai); a_d = DW'(32'hA000 + ai); ai++; a_busy = 1'b1; end
      if (!l_busy) begin l_r = AW'(8 + li); l_d = DW'(32'hB000 + li); li++; l_busy = 1'b1; end
      step();
      if (k < 4 && bus.stall_o && !(bus.alu_ready_o && bus.ld_ready_o)) saw_full = 1'b1;
    end
    chk("full_within_4", 64'(saw_full), 64'(1));

    // Back-pressure: ALU refills to full, then holds (r5, 0x55).
    n_55 = 0;
    for (int k = 0; k < 8 && a_busy; k++) begin
      if (!l_busy) begin l_r = AW'(8 + li); l_d = DW'(32'hB000 + li); li++; l_busy = 1'b1; end
      step();
    end
    a_r = AW'(5); a_d = DW'(32'h55); a_busy = 1'b1;
    rejects = 0; bp_acc = 1'b0;
    for (int k = 0; k < 10 && !bp_acc; k++) begin
      if (!l_busy) begin l_r = AW'(8 + li); l_d = DW'(32'hB000 + li); li++; l_busy = 1'b1; end
      #1;
      if (!bus.alu_ready_o) rejects++;
      step();
      bp_acc = !a_busy;
    end
    chk("bp_held_while_full", 64'(rejects > 0), 64'(1));
    chk("bp_accepted", 64'(bp_acc), 64'(1));
    l_busy = 1'b0;
    drain();
    chk("bp_written_once", 64'(n_55), 64'(1));

    // Random traffic with held requests.
    do_reset();
    for (int k = 0; k < 200; k++) begin
      if (!a_busy && $urandom_range(0, 99) < 60) begin
        a_r = AW'($urandom_range(0, 15)); a_d = $urandom(); a_busy = 1'b1;
      end
      if (!l_busy && $urandom_range(0, 99) < 60) begin
        l_r = AW'($urandom_range(0, 15)); l_d = $urandom(); l_busy = 1'b1;
      end
      step();
    end
    a_busy = 1'b0; l_busy = 1'b0;
    drain();

    // Reset mid-operation with both FIFOs full.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      a_r = AW'(k); a_d = DW'(32'hC0 + k); a_busy = 1'b1;
      l_r = AW'(8 + k); l_d = DW'(32'hD0 + k); l_busy = 1'b1;
      step();
    end
    chk("pre_reset_stall", 64'(bus.stall_o), 64'(1));
    do_reset();
    repeat (4) step();
    a_r = AW'(6); a_d = DW'(32'h66); a_busy = 1'b1;
    l_r = AW'(7); l_d = DW'(32'h77); l_busy = 1'b1;
    step();
    step();
    chk("post_reset_first_grant", 64'(bus.grant_o), 64'(0));
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
